fcmp_pipe: RTL and testbench

Two-stage pipelined IEEE-754 single-precision compare stage that sits directly after register-file read in the FP ALU path. It accepts operand pairs with a valid/ready handshake and classifies each operand (NaN, signalling NaN, zero). It produces an exact FEQ/FLT/FLE result with a destination tag and an invalid-operation flag. It also keeps a sticky invalid flag for the FP status register. Comparisons are exact: no epsilon tolerance.

---
 rtl/fcmp_pipe_if.sv | 31 +++
 rtl/fcmp_pipe.sv | 171 +++++++++++++++++
 tb/tb_fcmp_pipe.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcmp_pipe_if.sv
// Handshake and data bundle for the fcmp_pipe compare stage.
// The master side issues operand pairs and consumes results; the slave side is the compare pipe.
interface fcmp_pipe_if #(
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [31:0]      read_data1;
  logic [31:0]      read_data2;
  logic [TAG_W-1:0] rd_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      cmp_out;
  logic [TAG_W-1:0] out_tag;
  logic             out_nv;

  logic             flag_clr;
  logic             fflags_nv;

  modport master (
    output in_valid, op, read_data1, read_data2, rd_tag, out_ready, flag_clr,
    input  in_ready, out_valid, cmp_out, out_tag, out_nv, fflags_nv
  );

  modport slave (
    input  in_valid, op, read_data1, read_data2, rd_tag, out_ready, flag_clr,
    output in_ready, out_valid, cmp_out, out_tag, out_nv, fflags_nv
  );
endinterface

// File: rtl/fcmp_pipe.sv
// Two-stage pipelined IEEE-754 single-precision compare (FEQ/FLT/FLE) with
// valid/ready handshake, per-result invalid flag and a sticky invalid flag.
module fcmp_pipe #(
  parameter int unsigned TAG_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  fcmp_pipe_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] OP_FEQ = 2'b00;
  localparam logic [OP_W-1:0] OP_FLT = 2'b01;
  localparam logic [OP_W-1:0] OP_FLE = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] bits;
    logic              nan;
    logic              snan;
    logic              zero;
  } fp_opnd_t;

  function automatic fp_opnd_t classify(input logic [DATA_W-1:0] x);
    fp_opnd_t r;
    r.bits = x;
    r.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    r.snan = r.nan && !x[22];
    r.zero = (x[30:0] == 31'd0);
    return r;
  endfunction

  // Remaps sign-magnitude so an unsigned compare follows float order (non-NaN)
  function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  // Stage S1: captured operands and classification
  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_op_q,    s1_op_d;
  fp_opnd_t         s1_a_q,     s1_a_d;
  fp_opnd_t         s1_b_q,     s1_b_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  // Stage S2: registered result
  logic             s2_valid_q, s2_valid_d;
  logic             s2_cmp_q,   s2_cmp_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
  logic             s2_nv_q,    s2_nv_d;

  logic             fflags_q,   fflags_d;

  logic              s2_adv_c;
  logic              s1_adv_c;
  logic              accept_c;
  logic              out_xfer_c;
  logic [DATA_W-1:0] key_a_c;
  logic [DATA_W-1:0] key_b_c;
  logic              equal_c;
  logic              less_c;
  logic              any_nan_c;
  logic              res_cmp_c;
  logic              res_nv_c;

  // Handshake: S1 may move whenever S2 is empty or draining
  always_comb begin
    s2_adv_c   = !s2_valid_q || bus.out_ready;
    s1_adv_c   = !s1_valid_q || s2_adv_c;
    accept_c   = bus.in_valid && !rst && s1_adv_c;
    out_xfer_c = s2_valid_q && bus.out_ready;
  end

  assign bus.in_ready = !rst && s1_adv_c;

  // Exact compare on S1 contents; +0 and -0 compare equal
  always_comb begin
    key_a_c   = order_key(s1_a_q.bits);
    key_b_c   = order_key(s1_b_q.bits);
    equal_c   = (s1_a_q.bits == s1_b_q.bits) || (s1_a_q.zero && s1_b_q.zero);
    less_c    = !equal_c && (key_a_c < key_b_c);
    any_nan_c = s1_a_q.nan || s1_b_q.nan;
    res_cmp_c = 1'b0;
    res_nv_c  = 1'b0;
    case (s1_op_q)
      OP_FEQ: begin
        res_cmp_c = equal_c && !any_nan_c;
        res_nv_c  = s1_a_q.snan || s1_b_q.snan;
      end
      OP_FLT: begin
        res_cmp_c = less_c && !any_nan_c;
        res_nv_c  = any_nan_c;
      end
      OP_FLE: begin
        res_cmp_c = (less_c || equal_c) && !any_nan_c;
        res_nv_c  = any_nan_c;
      end
      default: begin
        res_cmp_c = 1'b0;
        res_nv_c  = 1'b0;
      end
    endcase
  end

  // Next-state for both stages and the sticky flag
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_cmp_d   = s2_cmp_q;
    s2_tag_d   = s2_tag_q;
    s2_nv_d    = s2_nv_q;

    if (s1_adv_c) begin
      s1_valid_d = accept_c;
    end
    if (accept_c) begin
      s1_op_d  = bus.op;
      s1_a_d   = classify(bus.read_data1);
      s1_b_d   = classify(bus.read_data2);
      s1_tag_d = bus.rd_tag;
    end

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_cmp_d = res_cmp_c;
        s2_tag_d = s1_tag_q;
        s2_nv_d  = res_nv_c;
      end
    end

    // A set on the same cycle as a clear must win
    fflags_d = (fflags_q && !bus.flag_clr) || (out_xfer_c && s2_nv_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_cmp_q   <= 1'b0;
      s2_tag_q   <= '0;
      s2_nv_q    <= 1'b0;
      fflags_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_cmp_q   <= s2_cmp_d;
      s2_tag_q   <= s2_tag_d;
      s2_nv_q    <= s2_nv_d;
      fflags_q   <= fflags_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.cmp_out   = DATA_W'(s2_cmp_q);
  assign bus.out_tag   = s2_tag_q;
  assign bus.out_nv    = s2_nv_q;
  assign bus.fflags_nv = fflags_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: directed plan steps plus a randomized phase, all checked
// against a real-valued reference model and an in-order result scoreboard.
module tb_fcmp_pipe;
  localparam int unsigned TAG_W = 5;

  logic clk = 1'b0;
  logic rst;

  fcmp_pipe_if #(.TAG_W(TAG_W)) bus ();
  fcmp_pipe #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic             cmp;
    logic [TAG_W-1:0] tag;
    logic             nv;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  logic fl_model = 1'b0;
  logic last_acc = 1'b0;

  logic [31:0] specials [12] = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
                                 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001,
                                 32'hFFC0_0000, 32'h0000_0001, 32'h8000_0001, 32'h7F7F_FFFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: float value as a real number; infinities map beyond the float range
  function automatic real fp_val(input logic [31:0] x);
    real mag;
    int  e;
    e = int'(x[30:23]);
    if (e == 255)    mag = 1.0e300;
    else if (e == 0) mag = real'(x[22:0]) * (2.0 ** real'(-149));
    else             mag = real'({1'b1, x[22:0]}) * (2.0 ** real'(e - 150));
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [TAG_W-1:0] tag);
    exp_t r;
    logic na, nb, sa, sb_;
    real  va, vb;
    r.tag = tag; r.cmp = 1'b0; r.nv = 1'b0;
    na = is_nan(a); nb = is_nan(b);
    sa = na && !a[22]; sb_ = nb && !b[22];
    if (op == 2'b11) begin
      r.cmp = 1'b0;
    end else if (na || nb) begin
      r.nv = (op == 2'b00) ? (sa || sb_) : 1'b1;
    end else begin
      va = fp_val(a); vb = fp_val(b);
      case (op)
        2'b00:   r.cmp = (va == vb);
        2'b01:   r.cmp = (va < vb);
        default: r.cmp = (va <= vb);
      endcase
    end
    return r;
  endfunction

  // One clock: record handshakes at negedge, check scoreboard and sticky flag
  task automatic cycle();
    logic acc, otr, fl_next;
    exp_t e;
    @(negedge clk);
    acc = ((bus.in_valid && bus.in_ready) === 1'b1);
    otr = ((bus.out_valid && bus.out_ready) === 1'b1);
    fl_next = bus.flag_clr ? 1'b0 : fl_model;
    if (rst) begin
      sb.delete();
      acc = 1'b0; otr = 1'b0; fl_next = 1'b0;
    end
    if (otr) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_cmp", bus.cmp_out, 32'(e.cmp));
        chk("sb_tag", 32'(bus.out_tag), 32'(e.tag));
        chk("sb_nv", 32'(bus.out_nv), 32'(e.nv));
        fl_next = fl_next | e.nv;
      end
    end
    if (acc) sb.push_back(ref_model(bus.op, bus.read_data1, bus.read_data2, bus.rd_tag));
    last_acc = acc;
    @(posedge clk);
    #1;
    fl_model = fl_next;
    chk("fflags_model", 32'(bus.fflags_nv), 32'(fl_model));
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1; bus.op = op; bus.read_data1 = a; bus.read_data2 = b; bus.rd_tag = tag;
  endtask

  // Single op through an empty pipe with out_ready high: latency and result
  task automatic run_one(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag,
                         input logic ec, input logic en);
    int lat;
    bus.out_ready = 1'b1;
    drive(op, a, b, tag);
    cycle();
    lat = 1;
    bus.in_valid = 1'b0;
    chk({nm, "_accept"}, 32'(last_acc), 32'd1);
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      cycle();
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    chk({nm, "_cmp"}, bus.cmp_out, 32'(ec));
    chk({nm, "_nv"}, 32'(bus.out_nv), 32'(en));
    chk({nm, "_tag"}, 32'(bus.out_tag), 32'(tag));
    cycle();
  endtask

  function automatic logic [31:0] rand_fp();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel < 3)      return $urandom;
    else if (sel < 6) return specials[$urandom_range(0, 11)];
    else              return {1'($urandom), 8'(8'd124 + 8'($urandom_range(0, 6))), 23'($urandom)};
  endfunction

  function automatic logic [31:0] pick_b(input logic [31:0] a);
    case ($urandom_range(0, 7))
      0, 1:    return rand_fp();
      2:       return a;
      3:       return a + 32'd1;
      4:       return a - 32'd1;
      5:       return a ^ 32'h8000_0000;
      default: return rand_fp();
    endcase
  endfunction

  initial begin : main
    exp_t        head;
    logic [31:0] ra;
    int          guard;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = 2'b00; bus.read_data1 = '0; bus.read_data2 = '0;
    bus.rd_tag = '0; bus.out_ready = 1'b0; bus.flag_clr = 1'b0;

    // Reset state
    cycle();
    cycle();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_cmp_out", bus.cmp_out, 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_out_nv", 32'(bus.out_nv), 32'd0);
    chk("rst_fflags", 32'(bus.fflags_nv), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic ordering
    run_one("fle_1_2", 2'b10, 32'h3F80_0000, 32'h4000_0000, 5'h03, 1'b1, 1'b0);
    run_one("fle_2_1", 2'b10, 32'h4000_0000, 32'h3F80_0000, 5'h04, 1'b0, 1'b0);

    // Zeros and exactness
    run_one("feq_pz_nz", 2'b00, 32'h0000_0000, 32'h8000_0000, 5'h05, 1'b1, 1'b0);
    run_one("flt_pz_nz", 2'b01, 32'h0000_0000, 32'h8000_0000, 5'h06, 1'b0, 1'b0);
    run_one("flt_ulp", 2'b01, 32'h3F80_0001, 32'h3F80_0000, 5'h07, 1'b0, 1'b0);
    run_one("feq_ulp", 2'b00, 32'h3F80_0001, 32'h3F80_0000, 5'h08, 1'b0, 1'b0);

    // Negatives and infinities
    run_one("fle_neg", 2'b10, 32'hC000_0000, 32'hBF80_0000, 5'h09, 1'b1, 1'b0);
    run_one("flt_neg", 2'b01, 32'hBF80_0000, 32'hC000_0000, 5'h0A, 1'b0, 1'b0);
    run_one("flt_inf", 2'b01, 32'hFF80_0000, 32'h7F80_0000, 5'h0B, 1'b1, 1'b0);

    // NaN handling and sticky flag
    run_one("feq_qnan", 2'b00, 32'h7FC0_0000, 32'h3F80_0000, 5'h0C, 1'b0, 1'b0);
    chk("fflags_after_qnan_feq", 32'(bus.fflags_nv), 32'd0);
    run_one("feq_snan", 2'b00, 32'h7F80_0001, 32'h3F80_0000, 5'h0D, 1'b0, 1'b1);
    chk("fflags_after_snan_feq", 32'(bus.fflags_nv), 32'd1);
    run_one("flt_qnan", 2'b01, 32'h7FC0_0000, 32'h3F80_0000, 5'h0E, 1'b0, 1'b1);
    run_one("op_rsvd", 2'b11, 32'h7F80_0001, 32'h3F80_0000, 5'h0F, 1'b0, 1'b0);
    bus.flag_clr = 1'b1;
    cycle();
    bus.flag_clr = 1'b0;
    chk("fflags_clr_alone", 32'(bus.fflags_nv), 32'd0);
    drive(2'b00, 32'h7F80_0001, 32'h3F80_0000, 5'h10);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    chk("clr_race_out_valid", 32'(bus.out_valid), 32'd1);
    bus.flag_clr = 1'b1;
    cycle();
    bus.flag_clr = 1'b0;
    chk("fflags_set_wins", 32'(bus.fflags_nv), 32'd1);

    // Backpressure with four back-to-back ops
    bus.out_ready = 1'b1;
    drive(2'b10, 32'h3F80_0000, 32'h3F80_0000, 5'h11);
    cycle();
    drive(2'b01, 32'hBF80_0000, 32'h3F80_0000, 5'h12);
    cycle();
    chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b0;
    drive(2'b00, 32'h4040_0000, 32'h4040_0000, 5'h13);
    #1;
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      head = sb[0];
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_cmp", bus.cmp_out, 32'(head.cmp));
      chk("bp_hold_tag", 32'(bus.out_tag), 32'(head.tag));
      chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_no_gap", 32'(bus.out_valid), 32'd1);
      if (i == 1)      drive(2'b10, 32'h7F80_0000, 32'hFF80_0000, 5'h14);
      else if (i > 1)  bus.in_valid = 1'b0;
      cycle();
    end
    chk("bp_all_delivered", 32'(sb.size()), 32'd0);

    // Reset mid-stream with both stages full
    run_one("pre_rst_nv", 2'b01, 32'h7FC0_0000, 32'h0000_0000, 5'h15, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    drive(2'b00, 32'h3F80_0000, 32'h3F80_0000, 5'h16);
    cycle();
    drive(2'b01, 32'h0000_0000, 32'h3F80_0000, 5'h17);
    cycle();
    bus.in_valid = 1'b0;
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_fflags", 32'(bus.fflags_nv), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("flush_no_ghost", 32'(bus.out_valid), 32'd0);
    end

    // Randomized traffic with random backpressure and flag clears
    bus.in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus.in_valid !== 1'b1 || last_acc) begin
        ra = rand_fp();
        drive(2'($urandom_range(0, 3)), ra, pick_b(ra), TAG_W'($urandom));
        bus.in_valid = ($urandom_range(0, 9) < 7);
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flag_clr  = ($urandom_range(0, 15) == 0);
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.flag_clr = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("rand_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
